label_uart_reporter: RTL and testbench
======================================

LABEL_UART_REPORTER -- requirements
Module: label_uart_reporter

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, giving the clock cycles per UART bit (100 MHz / 115200); legal values are 2 and above.
REQ-002 SHALL have parameter LABEL_WIDTH, default 4, giving the width of the classifier label input.
REQ-003 SHALL have parameter NUM_WIDTH, default 8, giving the width of the image-number input; legal values are 1 to 8.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, giving the result FIFO entry count; it must be a power of 2 and at least 2.
REQ-005 SHALL have port clock, input, 1 bit: the system clock; all logic is rising-edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port label, input, LABEL_WIDTH bits: the classified digit from the upstream classifier.
REQ-008 SHALL have port label_num, input, NUM_WIDTH bits: the index of the image that produced label.
REQ-009 SHALL have port label_ready, input, 1 bit: label and label_num are valid this cycle.
REQ-010 SHALL have port tx, output, 1 bit: UART 8N1 serial line, idle high, registered.
REQ-011 SHALL have port busy, output, 1 bit: high while the FIFO is not empty or a frame is in flight.
REQ-012 SHALL have port overflow, output, 1 bit: sticky flag that a result was dropped.

Function
REQ-013 SHALL capture {label_num, label} into the FIFO on every rising edge where label_ready=1 and the write is accepted; label_ready held high for N cycles means N captures.
REQ-014 SHALL accept a write when the FIFO count is below FIFO_DEPTH, or when a pop occurs on the same edge.
REQ-015 SHALL drop the write when the FIFO is full with no pop on the same edge, set overflow=1, and hold overflow=1 until reset.
REQ-016 SHALL run a transmit FSM with states IDLE, START, DATA, STOP and a frame byte index 0..2.
REQ-017 SHALL in IDLE, when the FIFO is non-empty, pop the head entry into a frame register on that edge, set the byte index to 0 and go to START.
REQ-018 SHALL drive tx low in START for CLKS_PER_BIT cycles, then go to DATA.
REQ-019 SHALL in DATA send 8 bits LSB first, each for CLKS_PER_BIT cycles, then go to STOP.
REQ-020 SHALL drive tx high in STOP for CLKS_PER_BIT cycles; then go to START with byte index+1 if byte index<2, else go to IDLE.
REQ-021 SHALL send byte 0 as label_num zero-extended to 8 bits.
REQ-022 SHALL send byte 1 as 0x30+label when label<=9, else 0x3F ('?').
REQ-023 SHALL send byte 2 as 0x0A.
REQ-024 SHALL have tx fall on the edge that pops the entry, which is the first rising edge after the capturing edge when IDLE and the FIFO were empty.
REQ-025 SHALL produce one frame of exactly 30*CLKS_PER_BIT cycles of tx activity.
REQ-026 SHALL send frames back-to-back: when the FIFO is non-empty at the end of STOP of byte 2, the FSM passes one cycle through IDLE with tx=1, then pops.
REQ-027 SHALL drive tx=1 in IDLE and STOP, and never glitch within a bit period.
REQ-028 SHALL count bit periods with a counter of width $clog2(CLKS_PER_BIT), reloaded at each bit boundary.
REQ-029 SHALL be unaffected by label_ready during transmission; captures continue into the FIFO.
REQ-030 SHALL send FIFO entries in capture order, with pointer wrap-around modulo FIFO_DEPTH.

Reset
REQ-031 SHALL on reset assertion immediately set tx=1, busy=0 and overflow=0, empty the FIFO (pointers and count to 0), set the FSM to IDLE, and clear the bit counter and byte index.
REQ-032 SHALL on reset mid-frame abort the frame with no further bits sent; the partial frame is not resumed.
REQ-033 SHALL ignore label_ready while reset=1; the first capture is possible on the first rising edge after deassertion.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-034 SHALL check: one-cycle label_ready with label=7, label_num=3 -> tx bytes 0x03, 0x37, 0x0A; tx low 1 edge after capture; busy low after 120 active cycles.
REQ-035 SHALL check: label=12, label_num=0xFF -> bytes 0xFF, 0x3F, 0x0A.
REQ-036 SHALL check: label_ready high for 6 consecutive cycles with labels 0..5 -> 5 frames with labels 0..4 in order; label 5 dropped; overflow=1 and held.
REQ-037 SHALL check: FIFO full and a label_ready on the same edge the IDLE pop occurs -> write accepted, no overflow, all 5 frames sent.
REQ-038 SHALL check: reset asserted during byte 1 data bits -> tx=1 immediately; after release, no further output and busy=0 until a new label_ready.
REQ-039 SHALL check: results 9 then 1 captured 50 cycles apart -> two frames separated by exactly one idle-high cycle, labels in order.

Source files
------------

// File: rtl/label_uart_reporter.sv
// ---------------------------------------------------------------------------
// label_uart_reporter
//
// Buffers classifier results in a small FIFO and reports each one over a
// UART 8N1 line as a three-byte frame:
//   byte 0 : image number, zero-extended to 8 bits
//   byte 1 : ASCII digit '0'..'9' for labels 0..9, '?' for anything larger
//   byte 2 : line feed (0x0A)
//
// Ports
//   clock       : system clock, rising edge
//   reset       : asynchronous, active-high reset
//   label       : classified digit from the upstream classifier
//   label_num   : index of the image that produced label
//   label_ready : label/label_num valid this cycle (one capture per cycle)
//   tx          : registered UART serial output, idle high
//   busy        : FIFO not empty or a frame is in flight
//   overflow    : sticky, set when a result had to be dropped
// ---------------------------------------------------------------------------
module label_uart_reporter #(
    parameter int CLKS_PER_BIT = 868,
    parameter int LABEL_WIDTH  = 4,
    parameter int NUM_WIDTH    = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [LABEL_WIDTH-1:0] label,
    input  logic [NUM_WIDTH-1:0]   label_num,
    input  logic                   label_ready,
    output logic                   tx,
    output logic                   busy,
    output logic                   overflow
);

    localparam int ENTRY_W = NUM_WIDTH + LABEL_WIDTH;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int COUNT_W = PTR_W + 1;
    localparam int CNT_W   = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0]   BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [COUNT_W-1:0] COUNT_FULL = COUNT_W'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // -----------------------------------------------------------------------
    // Result FIFO
    // -----------------------------------------------------------------------
    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [COUNT_W-1:0] fifo_count;
    logic               fifo_push;
    logic               fifo_pop;

    // -----------------------------------------------------------------------
    // Transmitter state
    // -----------------------------------------------------------------------
    logic [1:0]           state;
    logic [CNT_W-1:0]     bit_cnt;
    logic [2:0]           bit_idx;
    logic [1:0]           byte_idx;
    logic [ENTRY_W-1:0]   frame;
    logic [NUM_WIDTH-1:0] frame_num;
    logic [LABEL_WIDTH-1:0] frame_label;
    logic                 label_is_digit;
    logic [7:0]           cur_byte;
    logic                 bit_end;

    // The head entry leaves the FIFO on the same edge the FSM leaves IDLE.
    assign fifo_pop  = (state == ST_IDLE) && (fifo_count != '0);
    // A full FIFO still accepts a write when the head is popped on that edge.
    assign fifo_push = label_ready && ((fifo_count != COUNT_FULL) || fifo_pop);
    assign busy      = (fifo_count != '0) || (state != ST_IDLE);
    assign bit_end   = (bit_cnt == BIT_LAST);

    // NOTE: the storage array is deliberately left out of reset; the pointers
    // and count alone decide which entries are valid, so stale data is harmless.
    always_ff @(posedge clock) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr] <= {label_num, label};
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            // Power-of-two depth: pointers wrap naturally.
            if (fifo_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + COUNT_W'(1);
                2'b01:   fifo_count <= fifo_count - COUNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (label_ready && !fifo_push) begin
                overflow <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Byte currently being serialised, derived from the latched frame entry
    // -----------------------------------------------------------------------
    assign frame_num      = frame[ENTRY_W-1:LABEL_WIDTH];
    assign frame_label    = frame[LABEL_WIDTH-1:0];
    assign label_is_digit = (32'(frame_label) <= 32'd9);

    // NOTE: cur_byte gets a default before the case so no path can leave it
    // unassigned and infer a latch.
    always_comb begin
        cur_byte = 8'h0A;
        case (byte_idx)
            2'd0:    cur_byte = 8'(frame_num);
            2'd1:    cur_byte = label_is_digit ? (8'h30 + 8'(frame_label)) : 8'h3F;
            default: cur_byte = 8'h0A;
        endcase
    end

    // -----------------------------------------------------------------------
    // Transmit FSM. tx is registered and is loaded with the level of the next
    // bit on the edge that starts that bit, so it never changes mid-period.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            frame    <= '0;
            tx       <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx <= 1'b1;
                    if (fifo_pop) begin
                        frame    <= fifo_mem[rd_ptr];
                        byte_idx <= 2'd0;
                        bit_cnt  <= '0;
                        tx       <= 1'b0;
                        state    <= ST_START;
                    end
                end

                ST_START: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        bit_idx <= 3'd0;
                        tx      <= cur_byte[0];
                        state   <= ST_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end

                ST_DATA: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end

                ST_STOP: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (byte_idx == 2'd2) begin
                            // Always spend one cycle in IDLE before the next pop.
                            state <= ST_IDLE;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            tx       <= 1'b0;
                            state    <= ST_START;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_label_uart_reporter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_label_uart_reporter
//
// Directed stimulus pushes the expected UART bytes of every accepted result
// into a queue; an independent UART receiver decodes tx and compares each
// received byte against the head of that queue.
// ---------------------------------------------------------------------------
module tb_label_uart_reporter;

    localparam int CPB = 4;

    logic       clock;
    logic       reset;
    logic [3:0] label;
    logic [7:0] label_num;
    logic       label_ready;
    logic       tx;
    logic       busy;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] exp_q[$];
    int         starts[$];

    label_uart_reporter #(
        .CLKS_PER_BIT(CPB),
        .LABEL_WIDTH (4),
        .NUM_WIDTH   (8),
        .FIFO_DEPTH  (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .label      (label),
        .label_num  (label_num),
        .label_ready(label_ready),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic drive_label(input logic [3:0] lab, input logic [7:0] num);
        label       = lab;
        label_num   = num;
        label_ready = 1'b1;
    endtask

    task automatic exp_frame(input logic [7:0] b0, input logic [7:0] b1);
        exp_q.push_back(b0);
        exp_q.push_back(b1);
        exp_q.push_back(8'h0A);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clock);
            n++;
        end
        check("busy_clears", busy, 1'b0);
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        label_ready = 1'b0;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("reset_overflow", overflow, 1'b0);
        check("reset_tx", tx, 1'b1);
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // UART receiver / scoreboard monitor, sampling on falling edges.
    initial begin : monitor
        int         pos;
        int         b;
        bit         active;
        logic [7:0] shreg;
        pos    = 0;
        active = 1'b0;
        shreg  = '0;
        forever begin
            @(negedge clock);
            cyc++;
            if (reset) begin
                active = 1'b0;
            end else if (!active) begin
                if (tx === 1'b0) begin
                    active = 1'b1;
                    pos    = 0;
                    starts.push_back(cyc);
                end
            end else begin
                pos++;
                if (pos % CPB == CPB / 2) begin
                    b = pos / CPB;
                    if (b == 0) begin
                        check("start_bit", tx, 1'b0);
                    end else if (b <= 8) begin
                        shreg[b-1] = tx;
                    end else begin
                        check("stop_bit", tx, 1'b1);
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL unexpected_byte: got 0x%0h, required no byte (t=%0t)", shreg, $time);
                        end else begin
                            check("uart_byte", shreg, exp_q.pop_front());
                        end
                        active = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int errs;
        reset       = 1'b0;
        label       = '0;
        label_num   = '0;
        label_ready = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("reset_tx", tx, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_overflow", overflow, 1'b0);
        #20;
        @(negedge clock);
        reset = 1'b0;

        // Single result: label 7, image 3.
        @(negedge clock);
        drive_label(4'd7, 8'h03);
        exp_frame(8'h03, 8'h37);
        @(posedge clock); #1;
        label_ready = 1'b0;
        check("tx_idle_at_capture", tx, 1'b1);
        check("busy_after_capture", busy, 1'b1);
        @(posedge clock); #1;
        check("tx_fall_at_pop", tx, 1'b0);
        repeat (119) @(posedge clock);
        #1;
        check("busy_before_frame_end", busy, 1'b1);
        @(posedge clock); #1;
        check("busy_after_120", busy, 1'b0);
        @(negedge clock);
        check("scoreboard_drained", exp_q.size(), 0);

        // Non-digit label maps to '?'.
        @(negedge clock);
        drive_label(4'd12, 8'hFF);
        exp_frame(8'hFF, 8'h3F);
        @(negedge clock);
        label_ready = 1'b0;
        wait_idle(300);

        // Six back-to-back results: the sixth finds the FIFO full and is dropped.
        exp_frame(8'h10, 8'h30);
        exp_frame(8'h11, 8'h31);
        exp_frame(8'h12, 8'h32);
        exp_frame(8'h13, 8'h33);
        exp_frame(8'h14, 8'h34);
        @(negedge clock);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) check("overflow_before_drop", overflow, 1'b0);
            drive_label(4'(i), 8'h10 + 8'(i));
            @(negedge clock);
        end
        label_ready = 1'b0;
        check("overflow_on_drop", overflow, 1'b1);
        wait_idle(1000);
        check("overflow_held", overflow, 1'b1);
        do_reset();

        // Full FIFO plus a write on the same edge the IDLE pop happens.
        exp_frame(8'h20, 8'h39);
        exp_frame(8'h21, 8'h3F);
        exp_frame(8'h22, 8'h3F);
        exp_frame(8'h23, 8'h36);
        exp_frame(8'h24, 8'h38);
        exp_frame(8'h25, 8'h31);
        @(negedge clock);
        drive_label(4'd9,  8'h20); @(negedge clock);
        drive_label(4'd10, 8'h21); @(negedge clock);
        drive_label(4'd15, 8'h22); @(negedge clock);
        drive_label(4'd6,  8'h23); @(negedge clock);
        drive_label(4'd8,  8'h24); @(negedge clock);
        label_ready = 1'b0;
        repeat (117) @(negedge clock);
        check("tx_high_in_idle", tx, 1'b1);
        drive_label(4'd1, 8'h25);
        @(posedge clock); #1;
        label_ready = 1'b0;
        check("tx_fall_on_full_pop", tx, 1'b0);
        check("no_overflow_on_pop_write", overflow, 1'b0);
        wait_idle(1000);
        check("no_overflow_after_frames", overflow, 1'b0);

        // Reset during the data bits of byte 1.
        @(negedge clock);
        drive_label(4'd3, 8'h42);
        exp_frame(8'h42, 8'h33);
        @(negedge clock);
        label_ready = 1'b0;
        repeat (56) @(negedge clock);
        reset = 1'b1;
        label_ready = 1'b1;
        exp_q.delete();
        #1;
        check("tx_high_on_reset", tx, 1'b1);
        check("busy_low_on_reset", busy, 1'b0);
        repeat (3) @(negedge clock);
        label_ready = 1'b0;
        reset = 1'b0;
        errs = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (tx !== 1'b1 || busy !== 1'b0) errs++;
        end
        check("quiet_after_reset", errs, 0);

        // Two results 50 cycles apart: one idle-high cycle between frames.
        starts.delete();
        @(negedge clock);
        drive_label(4'd9, 8'h55);
        exp_frame(8'h55, 8'h39);
        @(negedge clock);
        label_ready = 1'b0;
        repeat (49) @(negedge clock);
        drive_label(4'd1, 8'hAA);
        exp_frame(8'hAA, 8'h31);
        @(negedge clock);
        label_ready = 1'b0;
        wait_idle(400);
        check("byte_starts", starts.size(), 6);
        if (starts.size() >= 4) begin
            check("byte_spacing", starts[1] - starts[0], 10 * CPB);
            check("frame_gap", starts[3] - starts[2], 10 * CPB + 1);
        end

        repeat (5) @(negedge clock);
        check("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
